// File: rtl/marker_phase_sequencer.sv
// Decodes testbench marker instructions on the commit lanes, tracks the test phase, times the
// transient-window close and queues cycle-stamped marker events. MARKER_WATCHDOG_EN adds the watchdog exit.
module marker_phase_sequencer #(
    parameter int               LANES      = 2,
    parameter int               WIN_DELAY  = 4,
    parameter int               FIFO_DEPTH = 8,
    parameter int               CNT_W      = 20,
    parameter logic [CNT_W-1:0] TIMEOUT    = 20'hFFFFF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [LANES-1:0]    commit_valid,
    input  logic [32*LANES-1:0] commit_inst,
    input  logic                spec_abort,
    input  logic                evt_ready,
    output logic                evt_valid,
    output logic [3:0]          evt_code,
    output logic [1:0]          evt_lane,
    output logic [CNT_W-1:0]    evt_cycle,
    output logic [3:0]          phase,
    output logic                window_done,
    output logic                exit_req,
    output logic                timeout,
    output logic                evt_overflow
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_RUN, S_ARMED, S_CLOSED, S_EXIT} state_t;
    state_t state;

    logic [CNT_W-1:0] cycle_cnt;
    logic [3:0]       win_cnt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, count, slot;
    logic [3:0]       q_code  [FIFO_DEPTH];
    logic [1:0]       q_lane  [FIFO_DEPTH];
    logic [CNT_W-1:0] q_cycle [FIFO_DEPTH];

    logic             live, trig, exit_hit, wd_fire, pop, ovf_now;
    logic [LANES-1:0] hit, push_en;
    logic [3:0]       code [LANES];
    logic [IDX_W-1:0] push_idx [LANES];
    logic [3:0]       next_phase;
    int               free_slots, n_acc;

    assign live      = (state != S_EXIT);
    assign count     = wr_ptr - rd_ptr;
    assign evt_valid = (wr_ptr != rd_ptr);
    assign pop       = evt_valid && evt_ready;
    assign evt_code  = evt_valid ? q_code[rd_ptr[IDX_W-1:0]]  : '0;
    assign evt_lane  = evt_valid ? q_lane[rd_ptr[IDX_W-1:0]]  : '0;
    assign evt_cycle = evt_valid ? q_cycle[rd_ptr[IDX_W-1:0]] : '0;

`ifdef MARKER_WATCHDOG_EN
    assign wd_fire = live && (cycle_cnt == TIMEOUT);
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // Marker decode; once in EXIT nothing is recognised, which freezes phase and the queue input.
    always_comb begin
        hit        = '0;
        trig       = 1'b0;
        exit_hit   = 1'b0;
        next_phase = phase;
        for (int i = 0; i < LANES; i++) begin
            code[i] = commit_inst[32*i+20 +: 4];
            if (live && commit_valid[i] && commit_inst[32*i +: 20] == 20'h02013 &&
                commit_inst[32*i+24 +: 8] == 8'h00 && code[i] != 4'hF) begin
                hit[i] = 1'b1;
                if (code[i] == 4'd1 || code[i] == 4'd4) trig = 1'b1;
                if (code[i] == 4'd14) exit_hit = 1'b1;
                else if (!code[i][0]) next_phase = code[i];
            end
        end
    end

    // Slots freed by this cycle's pop are available to this cycle's markers, lowest lane first.
    always_comb begin
        free_slots = FIFO_DEPTH - int'(count) + int'(pop);
        n_acc      = 0;
        push_en    = '0;
        ovf_now    = 1'b0;
        slot       = '0;
        for (int i = 0; i < LANES; i++) begin
            push_idx[i] = '0;
            if (hit[i]) begin
                if (n_acc < free_slots) begin
                    slot        = wr_ptr + PTR_W'(n_acc);
                    push_idx[i] = slot[IDX_W-1:0];
                    push_en[i]  = 1'b1;
                    n_acc       = n_acc + 1;
                end else begin
                    ovf_now = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_RUN;
            cycle_cnt    <= '0;
            win_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            phase        <= 4'hF;
            window_done  <= 1'b0;
            exit_req     <= 1'b0;
            evt_overflow <= 1'b0;
`ifdef MARKER_WATCHDOG_EN
            timeout      <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_code[i]  <= '0;
                q_lane[i]  <= '0;
                q_cycle[i] <= '0;
            end
        end else begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;

            // The window countdown keeps running even after EXIT is entered.
            if (win_cnt != '0) begin
                win_cnt <= win_cnt - 1'b1;
                if (win_cnt == 4'd1) window_done <= 1'b1;
            end

            case (state)
                S_RUN: begin
                    if (spec_abort) begin
                        state       <= S_CLOSED;
                        window_done <= 1'b1;
                    end else if (trig) begin
                        state   <= S_ARMED;
                        win_cnt <= 4'(WIN_DELAY);
                    end
                end
                S_ARMED: begin
                    if (spec_abort) begin
                        state       <= S_CLOSED;
                        window_done <= 1'b1;
                        win_cnt     <= '0;
                    end else if (win_cnt == 4'd1) begin
                        state <= S_CLOSED;
                    end
                end
                default: ;
            endcase

            if (exit_hit || wd_fire) begin
                state    <= S_EXIT;
                exit_req <= 1'b1;
            end
`ifdef MARKER_WATCHDOG_EN
            if (wd_fire) timeout <= 1'b1;
`endif
            phase <= next_phase;

            for (int i = 0; i < LANES; i++) begin
                if (push_en[i]) begin
                    q_code[push_idx[i]]  <= code[i];
                    q_lane[push_idx[i]]  <= 2'(i);
                    q_cycle[push_idx[i]] <= cycle_cnt;
                end
            end
            wr_ptr       <= wr_ptr + PTR_W'(n_acc);
            rd_ptr       <= rd_ptr + PTR_W'(pop);
            evt_overflow <= evt_overflow | ovf_now;
        end
    end
endmodule

// File: tb/tb_marker_phase_sequencer.sv
// Directed and randomized checks of marker_phase_sequencer against a queue/deadline reference model.
module tb_marker_phase_sequencer;
    localparam int               LANES      = 2;
    localparam int               WIN_DELAY  = 4;
    localparam int               FIFO_DEPTH = 8;
    localparam int               CNT_W      = 20;
    localparam logic [CNT_W-1:0] TIMEOUT    = 20'd100;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [LANES-1:0]    commit_valid = '0;
    logic [32*LANES-1:0] commit_inst = '0;
    logic                spec_abort = 1'b0;
    logic                evt_ready = 1'b0;
    logic                evt_valid;
    logic [3:0]          evt_code;
    logic [1:0]          evt_lane;
    logic [CNT_W-1:0]    evt_cycle;
    logic [3:0]          phase;
    logic                window_done, exit_req, timeout, evt_overflow;

    always #5 clock = ~clock;

    marker_phase_sequencer #(
        .LANES(LANES), .WIN_DELAY(WIN_DELAY), .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .spec_abort(spec_abort), .evt_ready(evt_ready), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_lane(evt_lane), .evt_cycle(evt_cycle), .phase(phase),
        .window_done(window_done), .exit_req(exit_req), .timeout(timeout),
        .evt_overflow(evt_overflow)
    );

    typedef struct packed {
        logic [3:0]       code;
        logic [1:0]       lane;
        logic [CNT_W-1:0] cyc;
    } ev_t;

    ev_t        mq[$];
    logic [3:0] m_phase;
    bit         m_done, m_exit, m_tmo, m_ovf, m_trig;
    int         m_done_at, m_e;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic logic [31:0] mk(input logic [3:0] c);
        return {8'h00, c, 20'h02013};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: markers are exact matches of mk(0..14); the window closes at an absolute deadline.
    task automatic model_edge();
        bit          exit_now, trig_now;
        logic [31:0] ins;
        exit_now = 0;
        trig_now = 0;
        if (!reset) begin
            mq.delete();
            m_phase = 4'hF; m_done = 0; m_exit = 0; m_tmo = 0; m_ovf = 0; m_trig = 0;
            m_done_at = -1; m_e = 0;
            return;
        end
        if (evt_ready && mq.size() > 0) void'(mq.pop_front());
        if (!m_exit) begin
            for (int i = 0; i < LANES; i++) begin
                ins = commit_inst[32*i +: 32];
                for (int c = 0; c < 15; c++) begin
                    if (commit_valid[i] && ins == mk(4'(c))) begin
                        if (mq.size() < FIFO_DEPTH) mq.push_back({4'(c), 2'(i), CNT_W'(m_e)});
                        else m_ovf = 1;
                        if (c == 14) exit_now = 1;
                        else if (c % 2 == 0) m_phase = 4'(c);
                        if (c == 1 || c == 4) trig_now = 1;
                    end
                end
            end
            if (spec_abort && !m_done) m_done = 1;
            else if (trig_now && !m_trig && !m_done) begin
                m_trig = 1;
                m_done_at = m_e + WIN_DELAY;
            end
`ifdef MARKER_WATCHDOG_EN
            if (m_e == int'(TIMEOUT)) begin
                m_tmo = 1;
                exit_now = 1;
            end
`endif
            if (exit_now) m_exit = 1;
        end
        if (m_done_at >= 0 && m_e >= m_done_at) m_done = 1;
        m_e++;
    endtask

    task automatic compare_all();
        ev_t h;
        bit  v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        check("evt_valid", 32'(evt_valid), 32'(v));
        check("evt_code", 32'(evt_code), 32'(h.code));
        check("evt_lane", 32'(evt_lane), 32'(h.lane));
        check("evt_cycle", 32'(evt_cycle), 32'(h.cyc));
        check("phase", 32'(phase), 32'(m_phase));
        check("window_done", 32'(window_done), 32'(m_done));
        check("exit_req", 32'(exit_req), 32'(m_exit));
        check("timeout", 32'(timeout), 32'(m_tmo));
        check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle();
        commit_valid = '0;
        commit_inst  = '0;
        spec_abort   = 1'b0;
    endtask

    task automatic lanes(input logic v0, input logic [31:0] i0, input logic v1, input logic [31:0] i1);
        commit_valid = {v1, v0};
        commit_inst  = {i1, i0};
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    logic [3:0]  rec[$];
    logic [31:0] rnd_ins;
    logic [3:0]  c0, c1;
    int          b;

    initial begin
        #2;
        do_reset();
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_phase", 32'(phase), 32'hF);
        check("rst_window_done", 32'(window_done), 32'd0);
        check("rst_exit_req", 32'(exit_req), 32'd0);
        check("rst_overflow", 32'(evt_overflow), 32'd0);

        // INIT_START at cycle 5
        evt_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        lanes(1'b1, 32'h00802013, 1'b0, 32'h0);
        step();
        check("init_phase", 32'(phase), 32'd8);
        check("init_code", 32'(evt_code), 32'd8);
        check("init_lane", 32'(evt_lane), 32'd0);
        check("init_cycle", 32'(evt_cycle), 32'd5);
        check("init_window", 32'(window_done), 32'd0);
        idle();
        step();
        check("init_drained", 32'(evt_valid), 32'd0);

        // Window timing, retrigger ignored
        do_reset();
        lanes(1'b0, 32'h0, 1'b1, 32'h00102013);
        step();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) lanes(1'b0, 32'h0, 1'b1, 32'h00102013);
            else idle();
            step();
            check("win_delay", 32'(window_done), 32'(k >= 4));
        end

        // spec_abort closes at once; later trigger is ignored
        do_reset();
        spec_abort = 1'b1;
        step();
        check("abort_done", 32'(window_done), 32'd1);
        idle();
        lanes(1'b1, 32'h00402013, 1'b0, 32'h0);
        step();
        idle();
        for (int k = 0; k < 6; k++) step();
        check("abort_still_done", 32'(window_done), 32'd1);

        // Overflow with consumer stalled
        do_reset();
        evt_ready = 1'b0;
        rec.delete();
        for (int k = 0; k < 5; k++) begin
            c0 = 4'(2 * $urandom_range(0, 6) + 1);
            c1 = 4'($urandom_range(0, 13));
            rec.push_back(c0);
            rec.push_back(c1);
            lanes(1'b1, mk(c0), 1'b1, mk(c1));
            step();
        end
        idle();
        step();
        check("ovf_flag", 32'(evt_overflow), 32'd1);
        check("ovf_valid_held", 32'(evt_valid), 32'd1);
        evt_ready = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            check("ovf_order_code", 32'(evt_code), 32'(rec[k]));
            check("ovf_order_lane", 32'(evt_lane), 32'(k % 2));
            step();
        end
        check("ovf_empty", 32'(evt_valid), 32'd0);

        // SIM_EXIT with a same-cycle VCTM_START, then markers ignored
        do_reset();
        evt_ready = 1'b0;
        lanes(1'b1, 32'h00e02013, 1'b1, 32'h00002013);
        step();
        check("exit_req", 32'(exit_req), 32'd1);
        check("exit_phase", 32'(phase), 32'd0);
        check("exit_head", 32'(evt_code), 32'd14);
        lanes(1'b1, 32'h00802013, 1'b1, 32'h00102013);
        step();
        idle();
        check("exit_frozen_phase", 32'(phase), 32'd0);
        evt_ready = 1'b1;
        step();
        check("exit_second_code", 32'(evt_code), 32'd0);
        check("exit_second_lane", 32'(evt_lane), 32'd1);
        step();
        check("exit_only_two", 32'(evt_valid), 32'd0);
        check("exit_no_window", 32'(window_done), 32'd0);

        // Watchdog
        do_reset();
        for (int k = 0; k < 100; k++) step();
        check("wd_before", 32'(timeout), 32'd0);
        step();
`ifdef MARKER_WATCHDOG_EN
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_exit", 32'(exit_req), 32'd1);
`else
        check("wd_timeout", 32'(timeout), 32'd0);
        check("wd_exit", 32'(exit_req), 32'd0);
`endif

        // Randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int k = 0; k < 70; k++) begin
                for (int i = 0; i < LANES; i++) begin
                    case ($urandom_range(0, 3))
                        0, 1: begin
                            c0 = ($urandom_range(0, 39) == 0) ? 4'd14 : 4'($urandom_range(0, 13));
                            if ($urandom_range(0, 9) == 0) c0 = 4'hF;
                            rnd_ins = mk(c0);
                        end
                        2: begin
                            b = $urandom_range(0, 27);
                            if (b >= 20) b = b + 4;
                            rnd_ins = mk(4'($urandom_range(0, 13))) ^ (32'h1 << b);
                        end
                        default: rnd_ins = $urandom;
                    endcase
                    commit_inst[32*i +: 32] = rnd_ins;
                    commit_valid[i] = ($urandom_range(0, 3) != 0);
                end
                spec_abort = ($urandom_range(0, 24) == 0);
                evt_ready  = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
